// File: rtl/mmio_bus_if.sv
// CPU-side memory-mapped bus: command, address, store data and load data.
// The CPU is the master; the MMIO controller is the slave.
interface mmio_bus_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// MMIO controller: decodes CPU accesses into RAM and a small I/O page holding
// output registers, synchronised input ports, a free-running cycle counter
// and a sticky bus-error status. Every read returns one cycle after the
// command edge, matching the synchronous RAM.
module mmio_bus_ctrl #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 9,
    parameter logic [ADDR_W-1:0] IO_BASE = 9'h100,
    parameter int                NUM_OUT = 2,
    parameter int                NUM_IN  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    mmio_bus_if.slave                 bus,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    output logic                      ram_write,
    input  logic [DATA_W-1:0]         ram_dout,
    input  logic [NUM_IN*DATA_W-1:0]  in_port,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic                      bus_err
);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    // I/O page offsets (relative to IO_BASE)
    localparam logic [ADDR_W-1:0] OUT_LIM  = ADDR_W'(NUM_OUT);
    localparam logic [ADDR_W-1:0] IN_LO    = ADDR_W'(8'h40);
    localparam logic [ADDR_W-1:0] IN_HI    = ADDR_W'(8'h40 + NUM_IN);
    localparam logic [ADDR_W-1:0] OFF_CNT  = ADDR_W'(8'h80);
    localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(8'h81);

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RAM  = 3'd1,
        SRC_OUT  = 3'd2,
        SRC_IN   = 3'd3,
        SRC_CNT  = 3'd4,
        SRC_STAT = 3'd5
    } src_e;

    // State
    logic [NUM_OUT*DATA_W-1:0] out_q,   out_d;
    logic [NUM_IN*DATA_W-1:0]  sync1_q, sync2_q;
    logic [DATA_W-1:0]         cnt_q,   cnt_d;
    logic                      err_q,   err_d;
    src_e                      sel_q,   sel_d;
    logic [DATA_W-1:0]         rd_val_q, rd_val_d;

    // Decode
    logic              is_rd_s, is_wr_s, is_ram_s;
    logic [ADDR_W-1:0] offset_s;
    logic              hit_out_s, hit_in_s, hit_cnt_s, hit_stat_s, unmapped_s;
    logic              err_set_s, err_clr_s;

    // RAM side is a straight pass-through; only the write enable is qualified.
    assign ram_addr  = bus.mem_addr;
    assign ram_din   = bus.write_data;
    assign ram_write = is_wr_s & is_ram_s;

    assign out_port = out_q;
    assign bus_err  = err_q;

    // Load data: RAM data arrives a cycle late from the RAM itself; every
    // other source was captured on the command edge (zero for NONE).
    assign bus.read_data = (sel_q == SRC_RAM) ? ram_dout : rd_val_q;

    // Address decode and error classification of the current command
    always_comb begin
        is_rd_s    = (bus.mem_cmd == CMD_READ);
        is_wr_s    = (bus.mem_cmd == CMD_WRITE);
        is_ram_s   = (bus.mem_addr < IO_BASE);
        offset_s   = bus.mem_addr - IO_BASE;
        hit_out_s  = !is_ram_s && (offset_s < OUT_LIM);
        hit_in_s   = !is_ram_s && (offset_s >= IN_LO) && (offset_s < IN_HI);
        hit_cnt_s  = !is_ram_s && (offset_s == OFF_CNT);
        hit_stat_s = !is_ram_s && (offset_s == OFF_STAT);
        unmapped_s = !is_ram_s && !(hit_out_s || hit_in_s || hit_cnt_s || hit_stat_s);
        err_set_s  = (bus.mem_cmd == CMD_RSVD)
                   | ((is_rd_s | is_wr_s) & unmapped_s)
                   | (is_wr_s & hit_in_s);
        err_clr_s  = is_wr_s & hit_stat_s & bus.write_data[0];
    end

    // Next-state for output registers, counter and sticky error flag
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_d[i*DATA_W +: DATA_W] = (is_wr_s && hit_out_s && offset_s == ADDR_W'(i))
                                      ? bus.write_data : out_q[i*DATA_W +: DATA_W];
        end
        // A write to the counter wins over the increment.
        cnt_d = (is_wr_s && hit_cnt_s) ? {DATA_W{1'b0}} : cnt_q + DATA_W'(1);
        // Setting the error wins over clearing it.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Read source select and capture of I/O data at the command edge
    always_comb begin
        sel_d    = SRC_NONE;
        rd_val_d = {DATA_W{1'b0}};
        if (is_rd_s) begin
            if (is_ram_s) begin
                sel_d = SRC_RAM;
            end else if (hit_out_s) begin
                sel_d = SRC_OUT;
                for (int i = 0; i < NUM_OUT; i++) begin
                    rd_val_d = (offset_s == ADDR_W'(i)) ? out_q[i*DATA_W +: DATA_W] : rd_val_d;
                end
            end else if (hit_in_s) begin
                sel_d = SRC_IN;
                for (int j = 0; j < NUM_IN; j++) begin
                    rd_val_d = (offset_s == IN_LO + ADDR_W'(j)) ? sync2_q[j*DATA_W +: DATA_W] : rd_val_d;
                end
            end else if (hit_cnt_s) begin
                sel_d    = SRC_CNT;
                rd_val_d = cnt_q;
            end else if (hit_stat_s) begin
                sel_d    = SRC_STAT;
                rd_val_d = {{(DATA_W-1){1'b0}}, err_q};
            end else begin
                sel_d = SRC_NONE;
            end
        end else begin
            sel_d = SRC_NONE;
        end
    end

    // All registered state; reset forces the read path back to NONE at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= {(NUM_OUT*DATA_W){1'b0}};
            sync1_q  <= {(NUM_IN*DATA_W){1'b0}};
            sync2_q  <= {(NUM_IN*DATA_W){1'b0}};
            cnt_q    <= {DATA_W{1'b0}};
            err_q    <= 1'b0;
            sel_q    <= SRC_NONE;
            rd_val_q <= {DATA_W{1'b0}};
        end else begin
            out_q    <= out_d;
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            rd_val_q <= rd_val_d;
        end
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl: stimulus pushes the expected load data
// for each read; a monitor pops and compares one cycle after the command.
module tb_mmio_bus_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_write;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] in_port;
    logic [2*DATA_W-1:0] out_port;
    logic              bus_err;

    mmio_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mmio_bus_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_BASE(9'h100), .NUM_OUT(2), .NUM_IN(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
        .ram_dout(ram_dout), .in_port(in_port), .out_port(out_port), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in synchronous RAM with one-cycle read latency
    logic [DATA_W-1:0] mem [512];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int vectors = 0;
    int errors  = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bus command at the falling edge; reads queue their expected data.
    task automatic op(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp);
        @(negedge clk);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wdata;
        if (cmd == 2'b01) exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.mem_cmd = 2'b00;
        end
    endtask

    // Monitor: a read sampled at an edge must show its data just after that edge.
    initial begin
        logic was_rd;
        logic [DATA_W-1:0] e;
        forever begin
            @(posedge clk);
            was_rd = (bus.mem_cmd == 2'b01) && reset;
            #1;
            if (was_rd) begin
                if (exp_q.size() == 0) begin
                    chk("read_without_expect", 32'(bus.read_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data", 32'(bus.read_data), 32'(e));
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 16'h0000;
        reset          = 1'b0;
        bus.mem_cmd    = 2'b00;
        bus.mem_addr   = 9'h000;
        bus.write_data = 16'h0000;
        in_port        = 16'h0000;
        #3;
        chk("rst_read_data", 32'(bus.read_data), 32'h0);
        chk("rst_out_port", out_port, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Counter after 10 idle edges
        repeat (10) @(posedge clk);
        op(2'b01, 9'h180, 16'h0, 16'd10);

        // Output registers
        op(2'b10, 9'h100, 16'h00A5, 16'h0);
        op(2'b10, 9'h101, 16'h1234, 16'h0);
        op(2'b01, 9'h100, 16'h0, 16'h00A5);
        op(2'b01, 9'h101, 16'h0, 16'h1234);
        idle(1);
        #1 chk("out_port", out_port, 32'h1234_00A5);

        // RAM write / read and write-enable qualification
        op(2'b10, 9'h010, 16'hBEEF, 16'h0);
        #1 chk("ram_write_ram", 32'(ram_write), 32'h1);
        op(2'b01, 9'h010, 16'h0, 16'hBEEF);
        #1 chk("ram_write_read", 32'(ram_write), 32'h0);
        op(2'b10, 9'h100, 16'h00A5, 16'h0);
        #1 chk("ram_write_io", 32'(ram_write), 32'h0);

        // Input port through synchroniser
        @(negedge clk);
        in_port     = 16'h0155;
        bus.mem_cmd = 2'b00;
        idle(1);
        op(2'b01, 9'h140, 16'h0, 16'h0155);
        op(2'b10, 9'h140, 16'hFFFF, 16'h0);
        idle(1);
        #1 chk("err_in_write", 32'(bus_err), 32'h1);
        chk("out_after_in_write", out_port, 32'h1234_00A5);

        // Status read and clear
        op(2'b01, 9'h181, 16'h0, 16'h0001);
        op(2'b10, 9'h181, 16'h0001, 16'h0);
        op(2'b01, 9'h181, 16'h0, 16'h0000);
        idle(1);
        #1 chk("err_cleared", 32'(bus_err), 32'h0);

        // Unmapped read
        op(2'b01, 9'h1F0, 16'h0, 16'h0000);
        idle(1);
        #1 chk("err_unmapped", 32'(bus_err), 32'h1);
        op(2'b10, 9'h181, 16'h0001, 16'h0);
        idle(1);
        #1 chk("err_cleared2", 32'(bus_err), 32'h0);

        // Reserved command
        op(2'b11, 9'h010, 16'h0, 16'h0);
        #1 chk("ram_write_rsvd", 32'(ram_write), 32'h0);
        idle(1);
        #1 chk("err_reserved", 32'(bus_err), 32'h1);
        op(2'b10, 9'h181, 16'h0001, 16'h0);
        // Nonexistent IN[1] is unmapped
        op(2'b01, 9'h141, 16'h0, 16'h0000);
        idle(1);
        #1 chk("err_in1_unmapped", 32'(bus_err), 32'h1);

        // Counter clear then wrap
        op(2'b10, 9'h180, 16'h0, 16'h0);
        op(2'b01, 9'h180, 16'h0, 16'h0000);
        idle(65534);
        op(2'b01, 9'h180, 16'h0, 16'hFFFF);
        op(2'b01, 9'h180, 16'h0, 16'h0000);

        // Reset in the middle of a RAM read
        op(2'b01, 9'h010, 16'h0, 16'hBEEF);
        @(posedge clk);
        #2;
        bus.mem_cmd = 2'b00;
        reset = 1'b0;
        #1;
        chk("mid_reset_read_data", 32'(bus.read_data), 32'h0);
        chk("mid_reset_out_port", out_port, 32'h0);
        chk("mid_reset_bus_err", 32'(bus_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
